// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES serial-link master: state encoding,
// fixed frame lengths and the key-length helper.
package aes_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PAD,
      MSG,
      GAP,
      KEY,
      READ,
      DONE
   } state_t;

   localparam int MSG_LEN  = 128;
   localparam int READ_LEN = 129;

   // Key width in bits for an Nk-word key.
   function automatic int key_bits(input int nk);
      return nk * 32;
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, right-shift register. Serial data enters at the MSB and
// the LSB is the serial output, so bit 0 of the loaded word leaves first.
module spi_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         shift_i,
   input  logic         ser_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sr_q, sr_d;

   // Load has priority over shift; otherwise hold.
   always_comb begin
      sr_d = sr_q;
      if (load_i)
         sr_d = load_val_i;
      else if (shift_i)
         sr_d = {ser_i, sr_q[W-1:1]};
   end

   // Register with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!reset)
         sr_q <= '0;
      else
         sr_q <= sr_d;
   end

   assign q_o = sr_q;

endmodule

// File: rtl/aes_spi_master.sv
// Sequences one AES transaction on the serial link: pad bit, 128 message
// bits, gap bit, key bits (all LSB first), then a readback window whose
// first cycle is turnaround and whose remaining 128 cycles fill the result.
module aes_spi_master
   import aes_spi_pkg::*;
#(
   parameter int Nk       = 4,
   parameter int READ_LEN = 129
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [127:0]           data_in,
   input  logic [Nk*32-1:0]       key_in,
   output logic                   busy,
   output logic                   done,
   output logic [127:0]           result,
   output logic                   SIMO,
   output logic                   CSS,
   output logic                   mode,
   input  logic                   SOMI
);

   localparam int KW   = key_bits(Nk);
   localparam int CMAX = (KW > READ_LEN) ? KW : READ_LEN;
   localparam int CW   = $clog2(CMAX);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [127:0]    result_q, result_d;

   logic            accept;
   logic            msg_shift, key_shift, res_shift;
   logic [127:0]    msg_q;
   logic [KW-1:0]   key_q;
   logic [127:0]    res_q;

   assign accept = (state_q == IDLE) && start;

   spi_shift_reg #(.W(128)) u_msg (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept),
      .load_val_i (data_in),
      .shift_i    (msg_shift),
      .ser_i      (1'b0),
      .q_o        (msg_q)
   );

   spi_shift_reg #(.W(KW)) u_key (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept),
      .load_val_i (key_in),
      .shift_i    (key_shift),
      .ser_i      (1'b0),
      .q_o        (key_q)
   );

   spi_shift_reg #(.W(128)) u_res (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept),
      .load_val_i ('0),
      .shift_i    (res_shift),
      .ser_i      (SOMI),
      .q_o        (res_q)
   );

   // Only the serial ends of the load registers and the upper result bits
   // feed the datapath; the rest is storage.
   logic unused_sr;
   assign unused_sr = ^{msg_q[127:1], key_q[KW-1:1], res_q[0]};

   // Next-state and link outputs, decoded from the current state.
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      CSS       = 1'b1;
      mode      = 1'b0;
      SIMO      = 1'b0;
      msg_shift = 1'b0;
      key_shift = 1'b0;
      res_shift = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = PAD;
         end
         PAD: begin
            busy    = 1'b1;
            CSS     = 1'b0;
            state_d = MSG;
         end
         MSG: begin
            busy      = 1'b1;
            CSS       = 1'b0;
            SIMO      = msg_q[0];
            msg_shift = 1'b1;
            if (cnt_q == CW'(MSG_LEN - 1)) state_d = GAP;
         end
         GAP: begin
            busy    = 1'b1;
            CSS     = 1'b0;
            state_d = KEY;
         end
         KEY: begin
            busy      = 1'b1;
            CSS       = 1'b0;
            SIMO      = key_q[0];
            key_shift = 1'b1;
            if (cnt_q == CW'(KW - 1)) state_d = READ;
         end
         READ: begin
            busy      = 1'b1;
            CSS       = 1'b0;
            mode      = 1'b1;
            // Cycle 0 is turnaround; SOMI carries no data yet.
            res_shift = (cnt_q != '0);
            if (cnt_q == CW'(READ_LEN - 1)) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Shared phase counter: restarts on every state change, idles at zero.
   always_comb begin
      if (state_d != state_q || state_q == IDLE || state_q == DONE)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 1'b1;
   end

   // Result is captured on the edge that enters DONE, folding in the last
   // SOMI bit, so it is already valid while done is high.
   always_comb begin
      result_d = result_q;
      if (state_q == READ && cnt_q == CW'(READ_LEN - 1))
         result_d = {SOMI, res_q[127:1]};
   end

   // State, counter and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: table of frames run against Nk=4 and Nk=8
// instances with a behavioural slave that records the load stream and
// answers the readback, plus hand-written handshake and reset sequences.
module tb_aes_spi_master;

   localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K4  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

   logic clk = 1'b0;
   logic reset, start4, start8, SOMI;
   logic [127:0] data_in;
   logic [127:0] key4;
   logic [255:0] key8;
   logic busy4, done4, simo4, css4, mode4;
   logic busy8, done8, simo8, css8, mode8;
   logic [127:0] result4, result8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_spi_master #(.Nk(4), .READ_LEN(129)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .data_in(data_in), .key_in(key4),
      .busy(busy4), .done(done4), .result(result4), .SIMO(simo4), .CSS(css4),
      .mode(mode4), .SOMI(SOMI)
   );

   aes_spi_master #(.Nk(8), .READ_LEN(129)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .data_in(data_in), .key_in(key8),
      .busy(busy8), .done(done8), .result(result8), .SIMO(simo8), .CSS(css8),
      .mode(mode8), .SOMI(SOMI)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Slave behaviour: the two known AES vectors decrypt to PT; any other
   // block/key gets a fixed mixing so serialisation errors change the answer.
   function automatic logic [127:0] slave_fn(input logic [127:0] m, input logic [255:0] k, input int kw);
      if (kw == 128 && m == CT4 && k[127:0] == K4 && k[255:128] == '0) return PT;
      if (kw == 256 && m == CT8 && k == K8) return PT;
      return m ^ k[127:0] ^ k[255:128] ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   task automatic set_start(input bit nk8, input bit v);
      if (nk8) start8 = v; else start4 = v;
   endtask

   // Runs one frame starting at a negedge; ends on a negedge.
   task automatic run_frame(input string nm, input bit nk8, input logic [127:0] d,
                            input logic [255:0] k, input bit turn, input bit fen,
                            input logic [127:0] fresp, input logic [127:0] exp_res,
                            input int hold, input int pulse_at, input bit start_in_done);
      int kw = nk8 ? 256 : 128;
      logic bq[$];
      int done_n = -1, css_low = 0, rd = 0, busy_bad = 0, css_gap = 0, lb_bad = 0, tail_bad = 0;
      logic [127:0] resp = '0, res_at_done = '0, cm;
      logic [255:0] ck;
      logic o_css, o_mode, o_simo, o_busy, o_done;
      logic [127:0] o_res;
      data_in = d;
      key4    = k[127:0];
      key8    = k;
      set_start(nk8, 1'b1);
      @(posedge clk);
      for (int c = 1; c <= 700 && done_n < 0; c++) begin
         @(negedge clk);
         set_start(nk8, (c < hold) || (c == pulse_at));
         o_css  = nk8 ? css8 : css4;
         o_mode = nk8 ? mode8 : mode4;
         o_simo = nk8 ? simo8 : simo4;
         o_busy = nk8 ? busy8 : busy4;
         o_done = nk8 ? done8 : done4;
         o_res  = nk8 ? result8 : result4;
         if (!o_css && !o_mode) bq.push_back(o_simo);
         if (!o_css) css_low++;
         if (o_done) begin
            done_n = c;
            res_at_done = o_res;
            if (o_busy || !o_css || o_mode) busy_bad++;
         end else begin
            if (!o_busy) busy_bad++;
            if (o_css) css_gap++;
         end
         if (o_mode) begin
            if (rd == 0) begin
               cm = '0;
               ck = '0;
               for (int i = 0; i < 128; i++) if (bq.size() > i + 1) cm[i] = bq[i + 1];
               for (int j = 0; j < kw; j++) if (bq.size() > 130 + j) ck[j] = bq[130 + j];
               resp = fen ? fresp : slave_fn(cm, ck, kw);
            end
            SOMI = (rd == 0) ? turn : resp[rd - 1];
            rd++;
         end else begin
            SOMI = 1'b0;
         end
         data_in = {$urandom, $urandom, $urandom, $urandom};
         key4    = ~key4;
         key8    = ~key8;
      end
      SOMI = 1'b0;
      set_start(nk8, start_in_done);
      chk({nm, ".done_cycle"}, 256'(done_n + 1), 256'(261 + kw));
      chk({nm, ".busy_css_during_frame"}, 256'(busy_bad), 256'(0));
      chk({nm, ".css_high_inside_frame"}, 256'(css_gap), 256'(0));
      chk({nm, ".css_low_cycles"}, 256'(css_low), 256'(259 + kw));
      chk({nm, ".read_cycles"}, 256'(rd), 256'(129));
      chk({nm, ".load_len"}, 256'(bq.size()), 256'(130 + kw));
      for (int i = 0; i < bq.size(); i++) begin
         logic e;
         if (i == 0 || i == 129)  e = 1'b0;
         else if (i <= 128)       e = d[i - 1];
         else if (i < 130 + kw)   e = k[i - 130];
         else                     e = ~bq[i];
         if (bq[i] !== e) lb_bad++;
      end
      chk({nm, ".load_bits_bad"}, 256'(lb_bad), 256'(0));
      chk({nm, ".result"}, 256'(res_at_done), 256'(exp_res));
      // Afterwards the link must stay idle with the result held.
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         set_start(nk8, 1'b0);
         if ((nk8 ? done8 : done4) || (nk8 ? busy8 : busy4) || !(nk8 ? css8 : css4) ||
             (nk8 ? mode8 : mode4) || (nk8 ? result8 : result4) !== exp_res) tail_bad++;
      end
      chk({nm, ".idle_after_done"}, 256'(tail_bad), 256'(0));
   endtask

   typedef struct {
      string        nm;
      bit           nk8;
      logic [127:0] d;
      logic [255:0] k;
      bit           turn;
      bit           fen;
      logic [127:0] fresp;
      logic [127:0] exp_res;
   } vec_t;

   vec_t tv[8];

   initial begin
      logic [127:0] rd_d;
      logic [255:0] rd_k;
      reset = 1'b0; start4 = 1'b0; start8 = 1'b0; SOMI = 1'b0;
      data_in = '0; key4 = '0; key8 = '0;

      tv[0] = '{"lsb_only", 1'b0, 128'h1, 256'h0, 1'b0, 1'b0, 128'h0, slave_fn(128'h1, 256'h0, 128)};
      tv[1] = '{"fips_nk4", 1'b0, CT4, {128'h0, K4}, 1'b0, 1'b0, 128'h0, PT};
      tv[2] = '{"fips_nk8", 1'b1, CT8, K8, 1'b0, 1'b0, 128'h0, PT};
      tv[3] = '{"turnaround_drop", 1'b0, 128'h0123, 256'h0, 1'b1, 1'b1, 128'h0, 128'h0};
      tv[4] = '{"last_read_bit", 1'b0, 128'h4567, 256'h0, 1'b0, 1'b1,
                128'h80000000000000000000000000000000, 128'h80000000000000000000000000000000};
      for (int i = 5; i < 8; i++) begin
         rd_d = {$urandom, $urandom, $urandom, $urandom};
         rd_k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         if (i != 7) rd_k[255:128] = '0;
         tv[i] = '{"random", (i == 7), rd_d, rd_k, 1'b0, 1'b0, 128'h0,
                   slave_fn(rd_d, rd_k, (i == 7) ? 256 : 128)};
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.ctl4", {css4, mode4, simo4, busy4, done4}, 5'b10000);
      chk("reset.res4", result4, 128'h0);
      chk("reset.ctl8", {css8, mode8, simo8, busy8, done8}, 5'b10000);
      chk("reset.res8", result8, 128'h0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_frame(tv[i].nm, tv[i].nk8, tv[i].d, tv[i].k, tv[i].turn, tv[i].fen,
                   tv[i].fresp, tv[i].exp_res, 1, 0, 1'b0);

      // start held 3 cycles plus a pulse mid-frame: one frame only.
      run_frame("hold_and_pulse", 1'b0, CT4, {128'h0, K4}, 1'b0, 1'b0, 128'h0, PT, 3, 50, 1'b0);
      // start raised in the DONE cycle is dropped.
      run_frame("start_in_done", 1'b0, CT4, {128'h0, K4}, 1'b0, 1'b0, 128'h0, PT, 1, 0, 1'b1);

      // Reset during the KEY phase aborts and clears everything.
      data_in = CT4; key4 = K4; start4 = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 140; c++) begin
         @(negedge clk);
         start4 = 1'b0;
      end
      chk("midkey.in_frame", {css4, mode4, busy4}, 3'b001);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midkey.ctl", {css4, mode4, simo4, busy4, done4}, 5'b10000);
      chk("midkey.res", result4, 128'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("midkey.still_idle", {css4, busy4, done4}, 3'b100);
      run_frame("after_reset", 1'b0, CT4, {128'h0, K4}, 1'b0, 1'b0, 128'h0, PT, 1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_spi_master.md
Name: aes_spi_master

Overview:
Bus-side controller that sequences one AES serial transaction on the single-clock SPI link to the AES slave. It accepts a 128-bit block and an Nk-word key over a start/done handshake. It serialises both LSB-first with the required framing, then flips the link to readback mode and deserialises the 128-bit AES result. One transaction at a time; requesters are serialised by the start/busy handshake.

Parameters:
Nk, 4, key length in 32-bit words; legal 4, 6, 8; key width KW = Nk*32
READ_LEN, 129, readback window in cycles (1 turnaround cycle + 128 data cycles)

Ports:
clk  in  1  system clock, also the serial bit clock (one bit per cycle)
reset  in  1  synchronous, active-low reset
start  in  1  request pulse; accepted only when busy=0
data_in  in  128  block to process; sampled on the accepted start
key_in  in  KW  key; sampled on the accepted start
busy  out  1  high from the cycle after the accepted start until done
done  out  1  one-cycle pulse when result is valid
result  out  128  captured AES output; held until the next done
SIMO  out  1  serial data to slave
CSS  out  1  chip select, active-low
mode  out  1  0 = load phase, 1 = readback phase
SOMI  in  1  serial data from slave

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, CSS=1, mode=0, SIMO=0, busy=0, done=0, result=0, counters=0. Reset mid-transaction aborts immediately. No partial result is exposed.
- IDLE: CSS=1, mode=0, SIMO=0. On start=1, latch data_in and key_in into shift registers, clear bit counter, go to PAD.
- PAD (1 cycle): CSS=0, mode=0, SIMO=0 (dummy bit consumed by the slave's 129-cycle message window). Go to MSG.
- MSG (128 cycles): SIMO = msg_sr[0]; msg_sr shifts right each cycle. Bit k of data_in is driven in MSG cycle k. Go to GAP when counter reaches 127.
- GAP (1 cycle): CSS=0, mode=0, SIMO=0. Go to KEY.
- KEY (KW cycles): SIMO = key_sr[0]; key_sr shifts right. Bit k of key_in is driven in KEY cycle k. Go to READ after cycle KW-1.
- READ (READ_LEN cycles): CSS=0, mode=1, SIMO=0. Cycle r=0 is turnaround: the slave registers its first output, and SOMI is ignored. On cycles r=1..128, SOMI is shifted into res_sr from the MSB (right shift), so the SOMI sampled in cycle r becomes result bit r-1. After r=128, go to DONE.
- DONE (1 cycle): result <= res_sr, done=1, busy=0, CSS=1, mode=0. Next state IDLE.
- Latency: start accepted at edge T; done high in the cycle after edge T+1+128+1+KW+129+1. That is 389 cycles for Nk=4, 453 for Nk=6, 517 for Nk=8.
- busy=1 in PAD..READ. start while busy=1 is ignored (not queued). start in the DONE cycle is ignored; a new start is accepted only in IDLE.
- Counter: one shared counter of width clog2(max(KW, READ_LEN)), cleared on every state change. No wrap is observable.
- mode transitions only at the KEY→READ boundary (0→1) and the READ→DONE boundary (1→0). CSS is never high inside a frame.
- data_in/key_in changes after an accepted start have no effect on the transaction in flight.
- The slave's bit counters are cleared only by the slave's own reset. System integration must pulse the slave reset before each transaction; this block does not drive it.

Decomposition:
- Shared package aes_spi_pkg: state encoding (IDLE, PAD, MSG, GAP, KEY, READ, DONE), MSG_LEN=128, READ_LEN=129, function key_bits(Nk).
- One natural sub-module: spi_shift_reg, a parameterised-width parallel-load, right-shift register with serial-in/serial-out. It is instantiated for the message, the key and the result.
- FSM and counter stay in the top module.

Test Plan:
- Reset mid-KEY phase (reset=0 for 1 cycle) -> next cycle CSS=1, mode=0, busy=0, done=0, result=0; a following start runs a full 389-cycle frame.
- Nk=4, data_in=128'h0000...0001, key_in=0 -> SIMO=0 during PAD, SIMO=1 only in MSG cycle 0, SIMO=0 throughout GAP and KEY; CSS low for exactly 387 cycles.
- Nk=4, behavioural slave model with real AES, data_in=69c4e0d86a7b0430d8cdb78070b4c55a, key_in=000102030405060708090a0b0c0d0e0f -> done at cycle 389, result=00112233445566778899aabbccddeeff.
- Nk=8, key_in=000102...1f, data_in=8ea2b7ca516745bfeafc49904b496089 -> done at cycle 517, result=00112233445566778899aabbccddeeff.
- start held high for 3 cycles, and start pulsed again while busy -> exactly one frame and one done pulse; second request ignored.
- SOMI forced to 1 only in READ cycle r=0, else 0 -> result=0 (turnaround bit discarded). SOMI=1 only in r=128 -> result=128'h8000...0000.
